// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring core: (x, y) in Q3.29 -> magnitude and atan2(y, x).
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales the magnitude by 1/K.

module arctan_lookup #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       j,
    output logic [WIDTH-1:0] angle
);
    logic [31:0] a;

    // atan(2^-j) in Q3.29, rounded to nearest
    always_comb begin
        a = 32'd0;
        unique case (j)
            5'd0:  a = 32'd421657428;
            5'd1:  a = 32'd248918915;
            5'd2:  a = 32'd131521918;
            5'd3:  a = 32'd66762579;
            5'd4:  a = 32'd33510843;
            5'd5:  a = 32'd16771758;
            5'd6:  a = 32'd8387925;
            5'd7:  a = 32'd4194219;
            5'd8:  a = 32'd2097141;
            5'd9:  a = 32'd1048575;
            5'd10: a = 32'd524288;
            5'd11: a = 32'd262144;
            5'd12: a = 32'd131072;
            5'd13: a = 32'd65536;
            5'd14: a = 32'd32768;
            5'd15: a = 32'd16384;
            5'd16: a = 32'd8192;
            5'd17: a = 32'd4096;
            5'd18: a = 32'd2048;
            5'd19: a = 32'd1024;
            5'd20: a = 32'd512;
            5'd21: a = 32'd256;
            5'd22: a = 32'd128;
            5'd23: a = 32'd64;
            5'd24: a = 32'd32;
            5'd25: a = 32'd16;
            5'd26: a = 32'd8;
            5'd27: a = 32'd4;
            5'd28: a = 32'd2;
            default: a = 32'd0;
        endcase
        angle = WIDTH'(a);
    end
endmodule

module cordic_vectoring #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 29
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] mag_out,
    output logic signed [WIDTH-1:0] angle_out,
    output logic                    busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        GAIN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic signed [WIDTH-1:0] PI = WIDTH'(32'sh6487ED51);

    state_t state, state_n;

    logic signed [WIDTH-1:0] x, y, z;
    logic signed [WIDTH-1:0] x_n, y_n, z_n;
    logic signed [WIDTH-1:0] x0, y0, z0;
    logic [WIDTH-1:0]        atan_raw;
    logic signed [WIDTH-1:0] atan_j;
    logic [4:0]              cnt;
    logic                    zero;
    logic                    last;

    arctan_lookup #(.WIDTH(WIDTH)) u_atan (
        .j     (cnt),
        .angle (atan_raw)
    );

    assign atan_j    = atan_raw;
    assign last      = (cnt == 5'(ITERATIONS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Fold the left half-plane onto the right so the iterations converge
    always_comb begin
        x0 = x_in;
        y0 = y_in;
        z0 = '0;
        if (x_in[WIDTH-1]) begin
            x0 = -x_in;
            y0 = -y_in;
            z0 = y_in[WIDTH-1] ? -PI : PI;
        end
    end

    always_comb begin
        x_n = x - (y >>> cnt);
        y_n = y + (x >>> cnt);
        z_n = z - atan_j;
        if (!y[WIDTH-1]) begin
            x_n = x + (y >>> cnt);
            y_n = y - (x >>> cnt);
            z_n = z + atan_j;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [63:0] prod;
    assign prod = 64'(x) * 64'sh136E9DB5;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid) state_n = ITER;
`ifdef CORDIC_GAIN_COMP_EN
            ITER: if (last) state_n = GAIN;
`else
            ITER: if (last) state_n = DONE;
`endif
            GAIN: state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            zero      <= 1'b0;
            mag_out   <= '0;
            angle_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x    <= x0;
                        y    <= y0;
                        z    <= z0;
                        cnt  <= '0;
                        zero <= (x_in == '0) && (y_in == '0);
                    end
                end
                ITER: begin
                    x   <= x_n;
                    y   <= y_n;
                    z   <= z_n;
                    cnt <= cnt + 5'd1;
`ifndef CORDIC_GAIN_COMP_EN
                    if (last) begin
                        mag_out   <= x_n;
                        angle_out <= zero ? '0 : z_n;
                    end
`endif
                end
`ifdef CORDIC_GAIN_COMP_EN
                GAIN: begin
                    mag_out   <= prod[WIDTH+28:29];
                    angle_out <= zero ? '0 : z;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: vector table, random atan2 model, backpressure and reset.
// Expected results are queued at acceptance and checked when the result handshakes.

module tb_cordic_vectoring;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = 30;
    localparam bit GC  = 1'b1;
`else
    localparam int LAT = 29;
    localparam bit GC  = 1'b0;
`endif
    localparam logic signed [31:0] KM   = GC ? 32'sd536870912 : 32'sd884097683;
    localparam logic signed [31:0] DM   = GC ? 32'sd379625062 : 32'sd625151467;
    localparam logic signed [31:0] ONE  = 32'sh20000000;
    localparam logic signed [31:0] HALF = 32'sh10000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, busy;
    logic signed [31:0] x_in = '0;
    logic signed [31:0] y_in = '0;
    logic signed [31:0] mag_out, angle_out;

    always #5 clk = ~clk;

    cordic_vectoring dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out),
        .busy      (busy)
    );

    typedef struct {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] mag;
        logic signed [31:0] ang;
        int mtol;
        int atol;
        int acc;
    } vec_t;

    vec_t q[$];
    vec_t e;
    vec_t tbl[9];
    int total = 0;
    int bad = 0;
    int edges = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string nm, input longint act,
                         input longint exp, input longint tol);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        total++;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    function automatic vec_t mk(input logic signed [31:0] x, input logic signed [31:0] y,
                                input logic signed [31:0] m, input logic signed [31:0] a,
                                input int mt, input int at);
        vec_t v;
        v.x = x; v.y = y; v.mag = m; v.ang = a;
        v.mtol = mt; v.atol = at; v.acc = 0;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got 1 want 0");
                end else begin
                    check("latency", edges - q[0].acc, LAT, 0);
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                check("angle", angle_out, e.ang, e.atol);
                check("mag", mag_out, e.mag, e.mtol);
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input vec_t v);
        int n;
        @(posedge clk); #1;
        x_in = v.x;
        y_in = v.y;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            check("accept_timeout", 0, 1, 0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        v.acc = edges;
        q.push_back(v);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_queue_size", q.size(), 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1, v2;
        logic signed [31:0] m0, a0;
        logic ok;
        int n;
        real rx, ry, ra, rm;

        tbl[0] = mk(ONE, 32'sd0, KM, 32'sd0, 256, 64);
        tbl[1] = mk(32'sd0, ONE, KM, 32'sh3243F6A9, 256, 64);
        tbl[2] = mk(32'sd0, 32'shE0000000, KM, 32'shCDBC0957, 256, 64);
        tbl[3] = mk(32'shE0000000, 32'sd0, KM, 32'sh6487ED51, 256, 64);
        tbl[4] = mk(HALF, HALF, DM, 32'sh1921FB54, 256, 64);
        tbl[5] = mk(-HALF, HALF, DM, 32'sd1264972285, 256, 64);
        tbl[6] = mk(-HALF, -HALF, DM, -32'sd1264972285, 256, 64);
        tbl[7] = mk(HALF, -HALF, DM, 32'shE6DE04AC, 256, 64);
        tbl[8] = mk(32'sd0, 32'sd0, 32'sd0, 32'sd0, 0, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1, 0);
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_mag", mag_out, 0, 0);
        check("rst_angle", angle_out, 0, 0);
        check("rst_busy", busy, 0, 0);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i]);
            drain();
        end

        for (int i = 0; i < 5; i++) begin
            v1.x = $signed(32'($urandom_range(32'h4000_0000, 0)) - 32'sh2000_0000);
            v1.y = $signed(32'($urandom_range(32'h4000_0000, 0)) - 32'sh2000_0000);
            rx = real'(v1.x);
            ry = real'(v1.y);
            ra = $atan2(ry, rx);
            rm = $sqrt(rx * rx + ry * ry) * (GC ? 1.0 : 884097683.0 / 536870912.0);
            v1.ang = 32'($rtoi(ra * 536870912.0));
            v1.mag = 32'($rtoi(rm));
            v1.mtol = 256;
            v1.atol = 64;
            v1.acc = 0;
            send(v1);
            drain();
        end

        // Backpressure: result held in DONE, second vector waits for IDLE
        out_ready = 1'b0;
        send(tbl[0]);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", out_valid, 1, 0);
        m0 = mag_out;
        a0 = angle_out;
        v2 = tbl[6];
        @(posedge clk); #1;
        x_in = v2.x;
        y_in = v2.y;
        in_valid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (mag_out !== m0 || angle_out !== a0 || !out_valid || in_ready) ok = 1'b0;
        end
        check("bp_hold", ok, 1, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_popped", q.size(), 0, 0);
        check("bp_idle_in_ready", in_ready, 1, 0);
        check("bp_idle_out_valid", out_valid, 0, 0);
        @(posedge clk); #1;
        v2.acc = edges;
        q.push_back(v2);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_busy", busy, 1, 0);
        check("bp_second_in_ready", in_ready, 0, 0);
        out_ready = 1'b1;
        drain();

        // Reset in the middle of the iterations discards the vector
        send(tbl[4]);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1, 0);
        check("mid_rst_out_valid", out_valid, 0, 0);
        check("mid_rst_busy", busy, 0, 0);
        ok = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        check("mid_rst_no_result", ok, 0, 0);
        send(tbl[3]);
        drain();
        send(tbl[5]);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
- Iterative CORDIC core in vectoring mode. Input is a Cartesian vector (x, y) in Q3.29; outputs are the magnitude and the angle atan2(y, x) in Q3.29 radians.
- This is the inverse direction of the rotation datapath.
- Performs one micro-rotation per clock. It instantiates arctan_lookup for the per-iteration elementary angle.
- Sits between upstream sample producers and the phase/magnitude consumers behind a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32: data width of all vector/angle buses, Q3.29 format.
- ITERATIONS, 29: number of micro-rotations, indices j = 0..ITERATIONS-1. Legal range 1..29.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input vector valid
- in_ready  output  1  core can accept a vector
- x_in  input  WIDTH  signed Q3.29 x; legal range [-1.0, +1.0]
- y_in  input  WIDTH  signed Q3.29 y; legal range [-1.0, +1.0]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- mag_out  output  WIDTH  signed Q3.29 magnitude, always >= 0
- angle_out  output  WIDTH  signed Q3.29 angle in (-pi, +pi]
- busy  output  1  high while not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, mag_out=0, angle_out=0; internal x, y, z and the iteration counter are all 0.
- States:
  - IDLE: in_ready=1. An input is accepted when in_valid && in_ready at the clock edge; the state then goes to ITER.
  - ITER: one micro-rotation per cycle. When counter == ITERATIONS-1, the state goes to DONE (or GAIN with the optional feature enabled).
  - DONE: out_valid=1. The outputs hold until out_valid && out_ready; the state then returns to IDLE.
- Quadrant pre-rotation, applied to the input at capture:
  - If x_in < 0: x0 = -x_in, y0 = -y_in, z0 = (y_in >= 0) ? +pi : -pi.
  - Otherwise: x0 = x_in, y0 = y_in, z0 = 0.
  - pi = 0x6487ED51.
- Iteration i (counter value drives arctan_lookup j):
  - If y >= 0: x += y>>>i; y -= x>>>i; z += atan(i).
  - Else: x -= y>>>i; y += x>>>i; z -= atan(i).
  - All three updates use the pre-update x and y. Shifts are arithmetic.
  - Truncation only, no rounding. Wrap is impossible within the legal input range (max |x| ≈ 2.33).
- Results:
  - mag_out = final x. This is the raw magnitude scaled by K ≈ 1.64676.
  - angle_out = final z.
  - Outputs are registered and stable throughout DONE.
- Latency: with acceptance at edge k, out_valid rises after edge k+ITERATIONS (29 cycles by default). Throughput is one vector per ITERATIONS+2 cycles minimum.
- No input is accepted outside IDLE; in_ready=0 in ITER, GAIN and DONE.
- Backpressure: while out_ready=0, DONE holds indefinitely with the outputs unchanged.
- Result handshake and next input: after a result handshake, the next input cannot be accepted in the same cycle. IDLE is entered first.
- Special inputs:
  - x_in=0, y_in=0: angle_out=0, mag_out=0.
  - x_in=-1.0, y_in=0: angle_out=+pi.
- rst asserted in any state returns the core to IDLE at that edge. Any in-flight result is discarded and out_valid=0 on the next cycle.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - An extra state GAIN is inserted between ITER and DONE.
  - GAIN computes mag_out = (x * INV_K) >>> 29, with INV_K = 0x136E9DB5 (0.607253).
  - The multiply uses a 64-bit signed product, truncated.
  - Latency grows by 1 cycle.
- Undefined:
  - There is no GAIN state, and mag_out is the raw K-scaled x.
- angle_out is identical in both builds.

Test Plan:
- Reset value check: hold rst 3 cycles, then release -> in_ready=1, out_valid=0, mag_out=0, angle_out=0, busy=0.
- Positive real axis: x=0x20000000 (1.0), y=0 -> angle_out=0 ±64 LSB. mag_out ≈ 884097683 (K) ±256 LSB raw, or 0x20000000 ±256 LSB with gain compensation. out_valid exactly 29 cycles after acceptance (30 with gain).
- Positive imaginary axis: x=0, y=0x20000000 -> angle_out=0x3243F6A9 (pi/2) ±64 LSB.
- Negative imaginary axis: x=0, y=0xE0000000 -> angle_out=0xCDBC0957 (-pi/2) ±64 LSB.
- Negative real axis: x=0xE0000000 (-1.0), y=0 -> angle_out=0x6487ED51 (+pi) ±64 LSB.
- Diagonal: x=y=0x10000000 (0.5) -> angle_out=0x1921FB54 (pi/4) ±64 LSB. With gain compensation, mag_out=379625062 ±256 LSB.
- Handshake and backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Pulse out_ready -> IDLE next cycle. A new input is accepted only after that.
- Reset mid-operation: assert rst at iteration 10 -> out_valid never asserts for that vector, IDLE and in_ready=1 next cycle. A fresh vector then produces correct results.
